dmac_write_scheduler: RTL and testbench
=======================================

# dmac_write_scheduler

Per-channel write-job scheduler in front of `dmac_write_initiator`. Accepts one write job (start address, beat count) at a time from up to `CHANNEL_COUNT` DMA channels by round-robin arbitration. Splits each job into AXI INCR bursts of at most `MAX_BURST_LEN` beats that never cross a 4 KB boundary, and issues them on the initiator's `wr_req_*` interface. Tags each burst with the owning channel and pulses a per-channel done when the job's last burst is accepted.

## Interface
- `ADDR_WD`, 32, address width
- `DATA_WD`, 32, data width; `STRB_WD = DATA_WD/8` beat bytes
- `CHANNEL_COUNT`, 8, number of requesting channels
- `MAX_BURST_LEN`, 16, max beats per burst (power of 2, ≤256)
- `BEATS_WD`, 16, width of job beat count
- `clk` in 1: clock; single clock domain
- `rst` in 1: synchronous, active-high reset
- `ch_req_valid` in `[CHANNEL_COUNT]`: channel has a job
- `ch_req_ready` out `[CHANNEL_COUNT]`: job accepted (one-hot, at most one bit)
- `ch_req_addr` in `[CHANNEL_COUNT][ADDR_WD]`: start address, `STRB_WD`-aligned
- `ch_req_beats` in `[CHANNEL_COUNT][BEATS_WD]`: job length in beats, 0 allowed
- `ch_req_data_offset` in `[CHANNEL_COUNT][$clog2(ADDR_WD/8)]`: passed through per job
- `ch_done` out `[CHANNEL_COUNT]`: one-cycle pulse, job fully issued
- `wr_req_valid` out 1 / `wr_req_ready` in 1: burst handshake to initiator
- `wr_req_addr` out `ADDR_WD`: burst start address
- `wr_req_burst` out `axi4_pkg::BURST_BITS`: always INCR
- `wr_req_len` out `axi4_pkg::LEN_BITS`: beats-1
- `wr_req_size` out `axi4_pkg::SIZE_BITS`: constant `$clog2(STRB_WD)`
- `wr_req_data_offset` out `$clog2(ADDR_WD/8)`: latched from job
- `wr_req_channel` out `$clog2(CHANNEL_COUNT)`: owning channel of current burst

## Operation
- FSM states `IDLE`, `CALC`, `ISSUE`, `DONE`; reset state `IDLE`.
- **IDLE:** if any `ch_req_valid`, the arbiter picks the first valid channel at or after `rr_ptr`, wrapping modulo `CHANNEL_COUNT`.
  - `ch_req_ready[g]` is asserted combinationally that cycle.
  - Latch addr, beats, offset and `g`, then go to `CALC`.
  - With no valid channel, stay in `IDLE`.
- **CALC:** if `remaining == 0`, go to `DONE`. Otherwise register `len_beats` and go to `ISSUE`:
  - `to_4k = (4096 - addr[11:0]) >> $clog2(STRB_WD)`
  - `len_beats = min(remaining, MAX_BURST_LEN, to_4k)`, which is always ≥1 for aligned addresses.
- **ISSUE:** `wr_req_valid = 1`; `wr_req_len = len_beats - 1`.
  - On `wr_req_ready`: `addr += len_beats*STRB_WD`, `remaining -= len_beats`.
  - Then go to `DONE` if the new remaining is 0, else to `CALC`.
- **DONE:** `ch_done[g] = 1` for one cycle; `rr_ptr = g+1` (wrap); go to `IDLE`.
- Jobs are not interleaved: one channel owns the initiator until its job completes.
- Address arithmetic is modulo `2^ADDR_WD`. The 4 KB split makes wrap at the top of the address space unreachable mid-burst.
- Zero-beat job: accepted, no burst issued, `ch_done` pulsed.
- Reset mid-operation: the in-flight job is dropped without `ch_done`, and `rr_ptr = 0`.

## Timing
- All outputs reset to 0: `wr_req_*` fields, `ch_req_ready`, `ch_done` and `wr_req_channel`.
- Exception: `wr_req_size` is a constant.
- Job accept at cycle T gives `CALC` at T+1 and `wr_req_valid` at T+2.
- Burst accept at t gives the next `wr_req_valid` at t+2. Inter-burst gap is 1 cycle.
- Final burst accept at t gives `ch_done` at t+1. The next job can be accepted at t+2.
- While `wr_req_valid && !wr_req_ready`, every `wr_req_*` output is held stable.
- `wr_req_valid` never deasserts without acceptance, except on `rst`.
- `ch_req_ready` is asserted only in `IDLE` and depends only on registered state and `ch_req_valid`. There is no `ready→valid` loop.
- A channel deasserting valid while not granted is allowed and has no effect.

## Structure
- Extend `dmac_pkg`:
  - state enum `dmac_wsched_state_e`
  - `AXI_4K_BYTES = 4096`
  - job struct `dmac_wjob_t` (addr, beats, offset, channel)
- Burst and size constants come from `axi4_pkg`: `BURST_INCR`, `LEN_BITS`.
- Sub-module `dmac_rr_arbiter`:
  - parameter `N`
  - inputs `req[N]`, `ptr`
  - outputs `grant_onehot`, `grant_idx`, `any`
  - purely combinational, reusable by the read side.

## Test plan
Parameters `DATA_WD=32`, `MAX_BURST_LEN=16`.
- **Multi-burst job:** ch0 addr `0x1000`, beats 40 -> bursts (`0x1000`, len 15), (`0x1040`, len 15), (`0x1080`, len 7); channel 0; `ch_done[0]` one cycle after 3rd accept.
- **4 KB split:** ch2 addr `0x0FF0`, beats 10 -> (`0x0FF0`, len 3), (`0x1000`, len 5); `wr_req_channel = 2`.
- **Round-robin:** ch1, ch3, ch5 valid together from reset -> served 1, 3, 5. ch1 re-asserted during ch3's job -> order still 1, 3, 5, 1.
- **Backpressure:** `wr_req_ready` low 5 cycles during `ISSUE` -> `wr_req_valid`/addr/len/channel constant; exactly one burst counted on acceptance.
- **Zero beats:** ch7 beats 0 -> `ch_req_ready[7]` at T, `ch_done[7]` at T+2, `wr_req_valid` never asserted.
- **Reset mid-job:** `rst` during 2nd burst of the 40-beat job -> next cycle all outputs 0, no `ch_done`. Next job from ch0 restarts arbitration from `rr_ptr = 0`.

Source files
------------

// File: rtl/axi4_pkg.sv
// AXI4 address-channel field widths and burst encodings shared by the DMA engines.
package axi4_pkg;

  localparam int BURST_BITS = 2;
  localparam int LEN_BITS   = 8;
  localparam int SIZE_BITS  = 3;

  localparam logic [BURST_BITS-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_BITS-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_BITS-1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/dmac_pkg.sv
// DMA controller shared types: write-scheduler state encoding and the latched job record.
package dmac_pkg;

  localparam int AXI_4K_BYTES   = 4096;

  localparam int DMAC_ADDR_WD   = 32;
  localparam int DMAC_BEATS_WD  = 16;
  localparam int DMAC_OFFSET_WD = 2;
  localparam int DMAC_CH_WD     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } dmac_wsched_state_e;

  typedef struct packed {
    logic [DMAC_ADDR_WD-1:0]   addr;
    logic [DMAC_BEATS_WD-1:0]  beats;
    logic [DMAC_OFFSET_WD-1:0] offset;
    logic [DMAC_CH_WD-1:0]     channel;
  } dmac_wjob_t;

endpackage

// File: rtl/dmac_rr_arbiter.sv
// Round-robin pick of the first requester at or after ptr, wrapping modulo N.
// Purely combinational (zero latency); no backpressure, the caller decides when a grant is taken.
module dmac_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int j;
    j            = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any && req[j]) begin
        any             = 1'b1;
        grant_onehot[j] = 1'b1;
        grant_idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/dmac_write_scheduler.sv
// Round-robin write-job scheduler: splits each channel job into <=MAX_BURST_LEN INCR bursts within 4 KB.
// Job accept -> first burst valid 2 cycles later, 1-cycle gap between bursts; wr_req_* held while !wr_req_ready.
module dmac_write_scheduler
  import dmac_pkg::*;
#(
  parameter int ADDR_WD       = DMAC_ADDR_WD,
  parameter int DATA_WD       = 32,
  parameter int CHANNEL_COUNT = 8,
  parameter int MAX_BURST_LEN = 16,
  parameter int BEATS_WD      = DMAC_BEATS_WD
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CHANNEL_COUNT-1:0]              ch_req_valid,
  output logic [CHANNEL_COUNT-1:0]              ch_req_ready,
  input  logic [CHANNEL_COUNT*ADDR_WD-1:0]      ch_req_addr,
  input  logic [CHANNEL_COUNT*BEATS_WD-1:0]     ch_req_beats,
  input  logic [CHANNEL_COUNT*$clog2(ADDR_WD/8)-1:0] ch_req_data_offset,
  output logic [CHANNEL_COUNT-1:0]              ch_done,
  output logic                                  wr_req_valid,
  input  logic                                  wr_req_ready,
  output logic [ADDR_WD-1:0]                    wr_req_addr,
  output logic [axi4_pkg::BURST_BITS-1:0]       wr_req_burst,
  output logic [axi4_pkg::LEN_BITS-1:0]         wr_req_len,
  output logic [axi4_pkg::SIZE_BITS-1:0]        wr_req_size,
  output logic [$clog2(ADDR_WD/8)-1:0]          wr_req_data_offset,
  output logic [$clog2(CHANNEL_COUNT)-1:0]      wr_req_channel
);

  localparam int STRB_WD    = DATA_WD / 8;
  localparam int SIZE_SHIFT = $clog2(STRB_WD);
  localparam int OFF_WD     = $clog2(ADDR_WD / 8);
  localparam int CH_WD      = $clog2(CHANNEL_COUNT);
  localparam int LB_WD      = $clog2(MAX_BURST_LEN) + 1;
  localparam int CW         = (BEATS_WD > 14) ? BEATS_WD : 14;
  localparam int LEN_WD     = axi4_pkg::LEN_BITS;
  localparam int SZ_WD      = axi4_pkg::SIZE_BITS;

  dmac_wsched_state_e state, state_nxt;
  dmac_wjob_t         job;
  logic [LB_WD-1:0]   len_beats;
  logic [CH_WD-1:0]   rr_ptr;

  logic [CHANNEL_COUNT-1:0] grant_onehot;
  logic [CH_WD-1:0]         grant_idx;
  logic                     grant_any;

  logic [ADDR_WD-1:0]  addr_arr  [CHANNEL_COUNT];
  logic [BEATS_WD-1:0] beats_arr [CHANNEL_COUNT];
  logic [OFF_WD-1:0]   off_arr   [CHANNEL_COUNT];

  for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_unpack
    assign addr_arr[c]  = ch_req_addr[c*ADDR_WD +: ADDR_WD];
    assign beats_arr[c] = ch_req_beats[c*BEATS_WD +: BEATS_WD];
    assign off_arr[c]   = ch_req_data_offset[c*OFF_WD +: OFF_WD];
  end

  dmac_rr_arbiter #(
    .N  (CHANNEL_COUNT),
    .IW (CH_WD)
  ) u_arb (
    .req          (ch_req_valid),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  // Burst length: bounded by the remaining job, the burst cap and the distance to the next 4 KB page.
  logic [12:0]    to_4k_bytes;
  logic [CW-1:0]  to_4k_beats;
  logic [CW-1:0]  len_calc;

  always_comb begin
    to_4k_bytes = 13'(AXI_4K_BYTES) - {1'b0, job.addr[11:0]};
    to_4k_beats = CW'(to_4k_bytes >> SIZE_SHIFT);
    len_calc    = CW'(job.beats);
    if (len_calc > CW'(MAX_BURST_LEN)) len_calc = CW'(MAX_BURST_LEN);
    if (len_calc > to_4k_beats)        len_calc = to_4k_beats;
  end

  logic [ADDR_WD-1:0] addr_step;
  assign addr_step = ADDR_WD'(len_beats) << SIZE_SHIFT;

  assign wr_req_size = SZ_WD'(SIZE_SHIFT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    ch_req_ready       = '0;
    ch_done            = '0;
    wr_req_valid       = 1'b0;
    wr_req_addr        = '0;
    wr_req_burst       = '0;
    wr_req_len         = '0;
    wr_req_data_offset = '0;
    wr_req_channel     = '0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          ch_req_ready = grant_onehot;
          state_nxt    = CALC;
        end
      end
      CALC: begin
        state_nxt = (job.beats == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        wr_req_valid       = 1'b1;
        wr_req_addr        = job.addr;
        wr_req_burst       = axi4_pkg::BURST_INCR;
        wr_req_len         = LEN_WD'(len_beats - LB_WD'(1));
        wr_req_data_offset = job.offset;
        wr_req_channel     = job.channel;
        if (wr_req_ready)
          state_nxt = (job.beats == BEATS_WD'(len_beats)) ? DONE : CALC;
      end
      DONE: begin
        ch_done[job.channel] = 1'b1;
        state_nxt            = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      job       <= '0;
      len_beats <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            job.addr    <= addr_arr[grant_idx];
            job.beats   <= beats_arr[grant_idx];
            job.offset  <= off_arr[grant_idx];
            job.channel <= grant_idx;
          end
        end
        CALC: begin
          if (job.beats != '0) len_beats <= LB_WD'(len_calc);
        end
        ISSUE: begin
          if (wr_req_ready) begin
            job.addr  <= job.addr + addr_step;
            job.beats <= job.beats - BEATS_WD'(len_beats);
          end
        end
        DONE: begin
          rr_ptr <= (job.channel == CH_WD'(CHANNEL_COUNT - 1)) ? '0 : job.channel + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_write_scheduler.sv
// Directed bench for dmac_write_scheduler: burst splitting, 4 KB boundary, round-robin, backpressure, reset.
module tb_dmac_write_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   ch_req_valid;
  logic [7:0]   ch_req_ready;
  logic [255:0] ch_req_addr;
  logic [127:0] ch_req_beats;
  logic [15:0]  ch_req_data_offset;
  logic [7:0]   ch_done;
  logic         wr_req_valid;
  logic         wr_req_ready;
  logic [31:0]  wr_req_addr;
  logic [1:0]   wr_req_burst;
  logic [7:0]   wr_req_len;
  logic [2:0]   wr_req_size;
  logic [1:0]   wr_req_data_offset;
  logic [2:0]   wr_req_channel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmac_write_scheduler #(
    .ADDR_WD       (32),
    .DATA_WD       (32),
    .CHANNEL_COUNT (8),
    .MAX_BURST_LEN (16),
    .BEATS_WD      (16)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ch_req_valid       (ch_req_valid),
    .ch_req_ready       (ch_req_ready),
    .ch_req_addr        (ch_req_addr),
    .ch_req_beats       (ch_req_beats),
    .ch_req_data_offset (ch_req_data_offset),
    .ch_done            (ch_done),
    .wr_req_valid       (wr_req_valid),
    .wr_req_ready       (wr_req_ready),
    .wr_req_addr        (wr_req_addr),
    .wr_req_burst       (wr_req_burst),
    .wr_req_len         (wr_req_len),
    .wr_req_size        (wr_req_size),
    .wr_req_data_offset (wr_req_data_offset),
    .wr_req_channel     (wr_req_channel)
  );

  // {valid, burst, addr, len, channel, offset}
  logic [47:0] obs;
  assign obs = {wr_req_valid, wr_req_burst, wr_req_addr, wr_req_len, wr_req_channel, wr_req_data_offset};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_job(input int ch, input logic [31:0] a, input logic [15:0] b, input logic [1:0] o);
    ch_req_addr[ch*32 +: 32]       = a;
    ch_req_beats[ch*16 +: 16]      = b;
    ch_req_data_offset[ch*2 +: 2]  = o;
    ch_req_valid[ch]               = 1'b1;
  endtask

  // Returns before the accepting edge with the granted channel, or -1 on timeout.
  task automatic wait_grant(output int idx);
    idx = -1;
    #1;
    for (int i = 0; i < 40 && idx < 0; i++) begin
      for (int c = 0; c < 8; c++) if (ch_req_ready[c]) idx = c;
      if (idx < 0) tick();
    end
  endtask

  task automatic take_grant(input int idx);
    tick();
    if (idx >= 0) ch_req_valid[idx] = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (wr_req_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic accept();
    wr_req_ready = 1'b1;
    tick();
    wr_req_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wr_req_ready = 1'b0;
    ch_req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if (obs !== 48'h0) begin
      fails++; $display("FAIL reset_wr_req got %h want %h", obs, 48'h0);
    end
    tests++;
    if ({ch_req_ready, ch_done} !== 16'h0) begin
      fails++; $display("FAIL reset_ch_outs got %h want %h", {ch_req_ready, ch_done}, 16'h0);
    end
    tests++;
    if (wr_req_size !== 3'd2) begin
      fails++; $display("FAIL reset_size got %0d want 2", wr_req_size);
    end
    rst = 1'b0;
  endtask

  task automatic test_multi_burst();
    int g;
    set_job(0, 32'h1000, 16'd40, 2'd1);
    wait_grant(g);
    tests++;
    if (g !== 0) begin fails++; $display("FAIL mb_grant got %0d want 0", g); end
    take_grant(g);
    tests++;
    if (wr_req_valid !== 1'b0) begin fails++; $display("FAIL mb_calc_gap got %b want 0", wr_req_valid); end
    tick();
    tests++;
    if (obs !== {1'b1, 2'b01, 32'h1000, 8'd15, 3'd0, 2'd1}) begin
      fails++; $display("FAIL mb_burst1 got %h want %h", obs, {1'b1, 2'b01, 32'h1000, 8'd15, 3'd0, 2'd1});
    end
    accept();
    tests++;
    if ({wr_req_valid, ch_done} !== 9'h0) begin
      fails++; $display("FAIL mb_gap1 got %h want 0", {wr_req_valid, ch_done});
    end
    tick();
    tests++;
    if (obs !== {1'b1, 2'b01, 32'h1040, 8'd15, 3'd0, 2'd1}) begin
      fails++; $display("FAIL mb_burst2 got %h want %h", obs, {1'b1, 2'b01, 32'h1040, 8'd15, 3'd0, 2'd1});
    end
    accept();
    tick();
    tests++;
    if (obs !== {1'b1, 2'b01, 32'h1080, 8'd7, 3'd0, 2'd1}) begin
      fails++; $display("FAIL mb_burst3 got %h want %h", obs, {1'b1, 2'b01, 32'h1080, 8'd7, 3'd0, 2'd1});
    end
    accept();
    tests++;
    if ({wr_req_valid, ch_done} !== 9'h001) begin
      fails++; $display("FAIL mb_done got %h want 001", {wr_req_valid, ch_done});
    end
    tick();
    tests++;
    if (ch_done !== 8'h00) begin fails++; $display("FAIL mb_done_pulse got %h want 00", ch_done); end
  endtask

  task automatic test_4k_split();
    int g;
    logic ok;
    set_job(2, 32'h0000_0FF0, 16'd10, 2'd0);
    wait_grant(g);
    tests++;
    if (g !== 2) begin fails++; $display("FAIL k4_grant got %0d want 2", g); end
    take_grant(g);
    wait_valid(ok);
    tests++;
    if (obs !== {1'b1, 2'b01, 32'h0FF0, 8'd3, 3'd2, 2'd0}) begin
      fails++; $display("FAIL k4_burst1 got %h want %h", obs, {1'b1, 2'b01, 32'h0FF0, 8'd3, 3'd2, 2'd0});
    end
    accept();
    wait_valid(ok);
    tests++;
    if (obs !== {1'b1, 2'b01, 32'h1000, 8'd5, 3'd2, 2'd0}) begin
      fails++; $display("FAIL k4_burst2 got %h want %h", obs, {1'b1, 2'b01, 32'h1000, 8'd5, 3'd2, 2'd0});
    end
    accept();
    tests++;
    if (ch_done !== 8'h04) begin fails++; $display("FAIL k4_done got %h want 04", ch_done); end
    tick();
  endtask

  task automatic test_round_robin();
    int g;
    logic ok;
    int exp_order[4] = '{1, 3, 5, 1};
    do_reset();
    set_job(1, 32'h3000, 16'd1, 2'd0);
    set_job(3, 32'h3100, 16'd1, 2'd0);
    set_job(5, 32'h3200, 16'd1, 2'd0);
    for (int k = 0; k < 4; k++) begin
      wait_grant(g);
      tests++;
      if (g !== exp_order[k]) begin fails++; $display("FAIL rr_order%0d got %0d want %0d", k, g, exp_order[k]); end
      take_grant(g);
      if (g == 3) set_job(1, 32'h3300, 16'd1, 2'd0);
      wait_valid(ok);
      tests++;
      if (!ok || wr_req_channel !== 3'(exp_order[k])) begin
        fails++; $display("FAIL rr_channel%0d got %0d (valid %b) want %0d", k, wr_req_channel, ok, exp_order[k]);
      end
      accept();
      tick();
    end
  endtask

  task automatic test_zero_beats();
    int g;
    set_job(7, 32'h5000, 16'd0, 2'd3);
    wait_grant(g);
    tests++;
    if (g !== 7) begin fails++; $display("FAIL zb_grant got %0d want 7", g); end
    take_grant(g);
    tests++;
    if ({wr_req_valid, ch_done} !== 9'h000) begin
      fails++; $display("FAIL zb_t1 got %h want 000", {wr_req_valid, ch_done});
    end
    tick();
    tests++;
    if ({wr_req_valid, ch_done} !== 9'h080) begin
      fails++; $display("FAIL zb_done got %h want 080", {wr_req_valid, ch_done});
    end
    tick();
    tests++;
    if ({wr_req_valid, ch_done} !== 9'h000) begin
      fails++; $display("FAIL zb_after got %h want 000", {wr_req_valid, ch_done});
    end
  endtask

  task automatic test_backpressure();
    int g;
    int bursts;
    logic ok;
    set_job(4, 32'h2000, 16'd8, 2'd2);
    wait_grant(g);
    tests++;
    if (g !== 4) begin fails++; $display("FAIL bp_grant got %0d want 4", g); end
    take_grant(g);
    wait_valid(ok);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (obs !== {1'b1, 2'b01, 32'h2000, 8'd7, 3'd4, 2'd2}) begin
        fails++; $display("FAIL bp_hold%0d got %h want %h", i, obs, {1'b1, 2'b01, 32'h2000, 8'd7, 3'd4, 2'd2});
      end
      tick();
    end
    bursts = 0;
    wr_req_ready = 1'b1;
    if (wr_req_valid) bursts++;
    tick();
    tests++;
    if (ch_done !== 8'h10) begin fails++; $display("FAIL bp_done got %h want 10", ch_done); end
    for (int i = 0; i < 4; i++) begin
      if (wr_req_valid) bursts++;
      tick();
    end
    wr_req_ready = 1'b0;
    tests++;
    if (bursts !== 1) begin fails++; $display("FAIL bp_count got %0d want 1", bursts); end
  endtask

  task automatic test_reset_mid_job();
    int g;
    logic ok;
    set_job(0, 32'h1000, 16'd40, 2'd0);
    wait_grant(g);
    take_grant(g);
    wait_valid(ok);
    accept();
    tick();
    tests++;
    if (obs !== {1'b1, 2'b01, 32'h1040, 8'd15, 3'd0, 2'd0}) begin
      fails++; $display("FAIL rm_burst2 got %h want %h", obs, {1'b1, 2'b01, 32'h1040, 8'd15, 3'd0, 2'd0});
    end
    rst = 1'b1;
    tick();
    tests++;
    if ({obs, ch_req_ready, ch_done} !== 64'h0) begin
      fails++; $display("FAIL rm_outs got %h want 0", {obs, ch_req_ready, ch_done});
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({wr_req_valid, ch_done} !== 9'h000) begin
        fails++; $display("FAIL rm_quiet%0d got %h want 000", i, {wr_req_valid, ch_done});
      end
    end
    set_job(0, 32'h4000, 16'd1, 2'd0);
    set_job(6, 32'h4100, 16'd1, 2'd0);
    wait_grant(g);
    tests++;
    if (g !== 0) begin fails++; $display("FAIL rm_ptr_restart got %0d want 0", g); end
    take_grant(g);
    wait_valid(ok);
    tests++;
    if (obs !== {1'b1, 2'b01, 32'h4000, 8'd0, 3'd0, 2'd0}) begin
      fails++; $display("FAIL rm_new_burst got %h want %h", obs, {1'b1, 2'b01, 32'h4000, 8'd0, 3'd0, 2'd0});
    end
    accept();
    tick();
    ch_req_valid = '0;
  endtask

  initial begin
    rst                = 1'b1;
    ch_req_valid       = '0;
    ch_req_addr        = '0;
    ch_req_beats       = '0;
    ch_req_data_offset = '0;
    wr_req_ready       = 1'b0;
    test_reset();
    test_multi_burst();
    test_4k_split();
    test_round_robin();
    test_zero_beats();
    test_backpressure();
    test_reset_mid_job();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
